// File: rtl/run_cycle_ctrl_pkg.sv
// rtl/run_cycle_ctrl_pkg.sv - shared types and constants for the run/cycle controller
package run_cycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_STEP,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_FREE  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BOUND = 2'b10;

endpackage

// File: rtl/run_cycle_ctrl_if.sv
// rtl/run_cycle_ctrl_if.sv - controller-to-core handshake (enable, reset, completion)
interface run_cycle_ctrl_if;

  logic core_en;
  logic core_rstn;
  logic core_done;

  modport master (output core_en, output core_rstn, input core_done);
  modport slave  (input core_en, input core_rstn, output core_done);

endinterface

// File: rtl/run_cycle_ctrl_sync_edge.sv
// rtl/run_cycle_ctrl_sync_edge.sv - multi-flop synchroniser with rising-edge pulse
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // Shift the async level through the synchroniser and remember the last synced value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      last_q <= sync_q[STAGES-1];
    end
  end

  // Both operands are flops, so the pulse is clean; a held level yields a single pulse.
  assign pulse = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/run_cycle_ctrl.sv
// rtl/run_cycle_ctrl.sv - run controller FSM, saturating cycle counter and sticky status
module run_cycle_ctrl
  import run_cycle_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 run,
  input  logic [1:0]           mode,
  input  logic [CNT_W-1:0]     limit,
  run_cycle_ctrl_if.master     core,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     cycles,
  output logic                 ovf,
  output logic                 timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_d;
  logic             run_pulse;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] limit_q;
  logic             step_en, step_en_d;
  logic             active, hit_limit, finish;
  logic [CNT_W-1:0] cnt_inc;
  logic             core_en_d, core_rstn_d, busy_d, done_d;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rstn  (rstn),
    .d     (run),
    .pulse (run_pulse)
  );

  // Per-cycle counting terms: which cycles the core is enabled and what they would count to.
  always_comb begin
    active    = (state == ST_RUN) || ((state == ST_STEP) && step_en);
    cnt_inc   = (cycles == CNT_MAX) ? cycles : cycles + CNT_W'(1);
    hit_limit = (mode_q == MODE_BOUND) && (limit_q != '0) && (cnt_inc == limit_q);
    finish    = active && (core.core_done || hit_limit);
  end

  // State register, plus the one-cycle step enable that belongs with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      step_en <= 1'b0;
    end else begin
      state   <= state_d;
      step_en <= step_en_d;
    end
  end

  // Next-state logic; CLR looks at the live mode because it is being latched on this same edge.
  always_comb begin
    state_d   = state;
    step_en_d = 1'b0;
    case (state)
      ST_IDLE: if (run_pulse) state_d = ST_CLR;
      ST_CLR:  state_d = (mode == MODE_STEP) ? ST_STEP : ST_RUN;
      ST_RUN:  if (finish) state_d = ST_DONE;
      ST_STEP: begin
        if (finish) state_d = ST_DONE;
        else if (!step_en && run_pulse) step_en_d = 1'b1;
      end
      ST_DONE: if (run_pulse) state_d = ST_CLR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the outputs can be registered without lag.
  always_comb begin
    core_en_d   = (state_d == ST_RUN) || step_en_d;
    core_rstn_d = (state_d != ST_CLR);
    busy_d      = (state_d == ST_CLR) || (state_d == ST_RUN) || (state_d == ST_STEP);
    done_d      = (state_d == ST_DONE);
  end

  // Output registers; the reset values hold the core in reset until IDLE is reached.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core.core_en   <= 1'b0;
      core.core_rstn <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      core.core_en   <= core_en_d;
      core.core_rstn <= core_rstn_d;
      busy           <= busy_d;
      done           <= done_d;
    end
  end

  // Run configuration latch, saturating counter and sticky overflow/timeout flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q  <= MODE_FREE;
      limit_q <= '0;
      cycles  <= '0;
      ovf     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (state == ST_CLR) begin
        mode_q  <= mode;
        limit_q <= limit;
      end
      if (state_d == ST_CLR) begin
        cycles  <= '0;
        ovf     <= 1'b0;
        timeout <= 1'b0;
      end else if (active) begin
        cycles <= cnt_inc;
        if (cnt_inc == CNT_MAX) ovf <= 1'b1;
        if (hit_limit && !core.core_done) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_run_cycle_ctrl.sv
// tb/tb_run_cycle_ctrl.sv - scoreboard testbench for run_cycle_ctrl
module tb_run_cycle_ctrl;

  localparam int CNT_W = 4;

  typedef struct {
    int cyc;
    int ovf;
    int to;
    int en;
    int pul;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             run;
  logic [1:0]       mode;
  logic [CNT_W-1:0] limit;
  logic             busy, done, ovf, timeout;
  logic [CNT_W-1:0] cycles;

  run_cycle_ctrl_if cif ();

  run_cycle_ctrl #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .run     (run),
    .mode    (mode),
    .limit   (limit),
    .core    (cif),
    .busy    (busy),
    .done    (done),
    .cycles  (cycles),
    .ovf     (ovf),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  int   done_rises = 0;
  int   done_at = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c, input int o, input int t, input int e, input int p);
    exp_t x;
    x.cyc = c; x.ovf = o; x.to = t; x.en = e; x.pul = p;
    sb.push_back(x);
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick(4);
    run = 1'b0;
    tick(4);
  endtask

  task automatic wait_done(input int prev, input int budget);
    for (int i = 0; i < budget && done_rises == prev; i++) tick(1);
    chk("done_seen", done_rises - prev, 1);
  endtask

  // Core model: raises core_done on the done_at-th enabled cycle, only while enabled.
  int en_seen = 0;
  always @(negedge clk) begin
    if (!rstn || !cif.core_rstn) begin
      en_seen = 0;
      cif.core_done = 1'b0;
    end else if (cif.core_en) begin
      en_seen++;
      cif.core_done = (done_at != 0) && (en_seen == done_at);
    end else begin
      cif.core_done = 1'b0;
    end
  end

  // Monitor: counts enabled cycles/pulses per run and checks each done against the scoreboard.
  int   mon_en = 0, mon_pul = 0, clr_len = 0;
  logic en_q = 1'b0, done_q = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      mon_en = 0; mon_pul = 0; clr_len = 0; en_q = 1'b0; done_q = 1'b0;
    end else begin
      if (!cif.core_rstn && busy) begin
        clr_len++;
        mon_en = 0;
        mon_pul = 0;
      end else if (clr_len != 0) begin
        chk("clr_len", clr_len, 1);
        clr_len = 0;
      end
      if (cif.core_en) begin
        mon_en++;
        if (!en_q) mon_pul++;
      end
      en_q = cif.core_en;
      if (done && !done_q) begin
        done_rises++;
        chk("sb_pending", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t x;
          x = sb.pop_front();
          chk("cycles", cycles, x.cyc);
          chk("ovf", ovf, x.ovf);
          chk("timeout", timeout, x.to);
          chk("en_cycles", mon_en, x.en);
          chk("en_pulses", mon_pul, x.pul);
          chk("busy_at_done", busy, 0);
          chk("core_en_at_done", cif.core_en, 0);
        end
      end
      done_q = done;
    end
  end

  initial begin
    int prev, cnt;
    rstn = 1'b0; run = 1'b0; mode = 2'b00; limit = '0;
    tick(2);
    chk("rst_core_en", cif.core_en, 0);
    chk("rst_core_rstn", cif.core_rstn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_timeout", timeout, 0);
    rstn = 1'b1;
    tick(3);
    chk("idle_core_rstn", cif.core_rstn, 1);

    // 1 free-run, core_done on 10th enabled cycle
    mode = 2'b00; done_at = 10;
    push(10, 0, 0, 10, 1);
    prev = done_rises; pulse_run(); wait_done(prev, 60);

    // 2 bounded timeout, then limit coinciding with core_done
    mode = 2'b10; limit = 4'd5; done_at = 0;
    push(5, 0, 1, 5, 1);
    prev = done_rises; pulse_run(); wait_done(prev, 60);
    done_at = 5;
    push(5, 0, 0, 5, 1);
    prev = done_rises; pulse_run(); wait_done(prev, 60);

    // 3 single-step: start, then three step pulses
    mode = 2'b01; limit = '0; done_at = 3;
    push(3, 0, 0, 3, 3);
    prev = done_rises;
    pulse_run();
    repeat (3) pulse_run();
    wait_done(prev, 60);

    // 4 saturation at 15 with 20 enabled cycles
    mode = 2'b00; done_at = 20;
    push(15, 1, 0, 20, 1);
    prev = done_rises; pulse_run(); wait_done(prev, 80);

    // 6 restart from DONE clears status; run held high through DONE
    done_at = 3;
    push(3, 0, 0, 3, 1);
    prev = done_rises;
    run = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10 && !busy; i++) begin tick(1); cnt++; end
    chk("clr_busy", busy, 1);
    chk("clr_cycles", cycles, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_done", done, 0);
    chk("clr_core_rstn", cif.core_rstn, 0);
    wait_done(prev, 60);
    tick(10);
    chk("held_done", done, 1);
    chk("held_no_restart", done_rises - prev, 1);
    run = 1'b0; tick(4);

    // 6 run toggled during RUN is ignored
    done_at = 12;
    push(12, 0, 0, 12, 1);
    prev = done_rises;
    run = 1'b1; tick(4); run = 1'b0; tick(2);
    run = 1'b1; tick(4); run = 1'b0;
    wait_done(prev, 60);
    tick(10);
    chk("toggle_done", done, 1);
    chk("toggle_no_restart", done_rises - prev, 1);

    // 5 reset at RUN cycle 4
    done_at = 0;
    run = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 4; i++) begin
      tick(1);
      if (cif.core_en) cnt++;
    end
    chk("rst_wait", cnt, 4);
    rstn = 1'b0;
    #1;
    chk("mid_core_en", cif.core_en, 0);
    chk("mid_core_rstn", cif.core_rstn, 0);
    chk("mid_cycles", cycles, 0);
    chk("mid_busy", busy, 0);
    run = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(10);
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("post_core_en", cif.core_en, 0);
    chk("post_core_rstn", cif.core_rstn, 1);

    done_at = 2;
    push(2, 0, 0, 2, 1);
    prev = done_rises; pulse_run(); wait_done(prev, 60);

    tick(5);
    chk("sb_left", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
